fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with its IF/ID pipeline register.
//
// Owns the PC and drives a synchronous-read instruction memory whose data returns
// exactly one cycle after the request cycle. A one-entry hold buffer catches the
// in-flight return when decode stalls. Redirects from resolved branches and jumps
// kill everything in flight and restart fetch at the new target.
//
// Ports:
//   clk              system clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   stall            decode cannot accept a new instruction; IF/ID holds
//   redirect_valid   branch taken / jump resolved this cycle
//   redirect_target  new PC on redirect (low 2 bits dropped, flagged via misalign)
//   imem_req         read request to instruction memory this cycle
//   imem_addr        request address (current PC)
//   imem_rdata       instruction data, valid one cycle after the request
//   id_valid         IF/ID holds a live instruction
//   id_instr         IF/ID instruction, 32'h0 when id_valid=0
//   id_pc_plus4      PC of id_instr + 4
//   OpCode, Funct    id_instr[31:26], id_instr[5:0]
//   misalign         one-cycle pulse after a redirect with a non-word-aligned target
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        misalign
);

  logic [31:0] pcQ, pcD;
  logic        reqValidQ, reqValidD;
  logic [31:0] reqPcQ, reqPcD;
  logic        holdValidQ, holdValidD;
  logic [31:0] holdInstrQ, holdInstrD;
  logic [31:0] holdPcQ, holdPcD;
  logic        idValidQ, idValidD;
  logic [31:0] idInstrQ, idInstrD;
  logic [31:0] idPcPlus4Q, idPcPlus4D;
  logic        misalignQ, misalignD;

  always_comb begin
    pcD        = pcQ;
    reqValidD  = reqValidQ;
    reqPcD     = reqPcQ;
    holdValidD = holdValidQ;
    holdInstrD = holdInstrQ;
    holdPcD    = holdPcQ;
    idValidD   = idValidQ;
    idInstrD   = idInstrQ;
    idPcPlus4D = idPcPlus4Q;
    misalignD  = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over stall: any held or in-flight instruction is wrong-path.
      pcD        = {redirect_target[31:2], 2'b00};
      reqValidD  = 1'b0;
      holdValidD = 1'b0;
      idValidD   = 1'b0;
      idInstrD   = 32'h0;
      misalignD  = |redirect_target[1:0];
    end else if (stall) begin
      // No request is issued while stalled, so at most one return needs catching.
      if (reqValidQ) begin
        holdInstrD = imem_rdata;
        holdPcD    = reqPcQ;
        holdValidD = 1'b1;
        reqValidD  = 1'b0;
      end
    end else begin
      reqPcD    = pcQ;
      reqValidD = 1'b1;
      pcD       = pcQ + 32'd4;
      if (holdValidQ) begin
        idInstrD   = holdInstrQ;
        idPcPlus4D = holdPcQ + 32'd4;
        idValidD   = 1'b1;
        holdValidD = 1'b0;
      end else if (reqValidQ) begin
        idInstrD   = imem_rdata;
        idPcPlus4D = reqPcQ + 32'd4;
        idValidD   = 1'b1;
      end else begin
        idValidD = 1'b0;
        idInstrD = 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcQ        <= RESET_PC;
      reqValidQ  <= 1'b0;
      reqPcQ     <= 32'h0;
      holdValidQ <= 1'b0;
      holdInstrQ <= 32'h0;
      holdPcQ    <= 32'h0;
      idValidQ   <= 1'b0;
      idInstrQ   <= 32'h0;
      idPcPlus4Q <= 32'h0;
      misalignQ  <= 1'b0;
    end else begin
      pcQ        <= pcD;
      reqValidQ  <= reqValidD;
      reqPcQ     <= reqPcD;
      holdValidQ <= holdValidD;
      holdInstrQ <= holdInstrD;
      holdPcQ    <= holdPcD;
      idValidQ   <= idValidD;
      idInstrQ   <= idInstrD;
      idPcPlus4Q <= idPcPlus4D;
      misalignQ  <= misalignD;
    end
  end

  assign imem_req    = !reset && !redirect_valid && !stall;
  assign imem_addr   = pcQ;
  assign id_valid    = idValidQ;
  assign id_instr    = idInstrQ;
  assign id_pc_plus4 = idPcPlus4Q;
  assign OpCode      = idInstrQ[31:26];
  assign Funct       = idInstrQ[5:0];
  assign misalign    = misalignQ;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] B = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc_plus4;
  logic [5:0]  OpCode, Funct;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(B)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .OpCode(OpCode), .Funct(Funct), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Address-tagged instruction words; garbage when no request was made.
  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mk(imem_addr);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks IF/ID contents against a live instruction at PC (pc4 - 4).
  task automatic chkId(input string name, input logic [31:0] pc4);
    logic [31:0] e;
    e = mk(pc4 - 32'd4);
    chk({name, ".valid"}, {31'b0, id_valid}, 32'd1);
    chk({name, ".pc4"}, id_pc_plus4, pc4);
    chk({name, ".instr"}, id_instr, e);
    chk({name, ".opcode"}, {26'b0, OpCode}, {26'b0, e[31:26]});
    chk({name, ".funct"}, {26'b0, Funct}, {26'b0, e[5:0]});
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc4;
    logic        expMis;
  } vec_t;

  vec_t vec[$];

  initial begin
    logic [31:0] nextPc4;
    logic [31:0] pat;

    // stall rv target | req addr | valid pc4 mis
    vec.push_back(vec_t'{0, 0, 0,           1, B,         0, 0,         0}); // 0 issue B
    vec.push_back(vec_t'{0, 0, 0,           1, B+4,       1, B+4,       0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+8,       1, B+8,       0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+'hC,     1, B+'hC,     0}); // IF/ID PC B+8
    vec.push_back(vec_t'{1, 0, 0,           0, B+'h10,    1, B+'hC,     0}); // stall x3
    vec.push_back(vec_t'{1, 0, 0,           0, B+'h10,    1, B+'hC,     0});
    vec.push_back(vec_t'{1, 0, 0,           0, B+'h10,    1, B+'hC,     0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h10,    1, B+'h10,    0}); // from hold
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h14,    1, B+'h14,    0});
    vec.push_back(vec_t'{0, 1, B+'h100,     0, B+'h18,    0, 0,         0}); // redirect
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h100,   0, 0,         0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h104,   1, B+'h104,   0});
    vec.push_back(vec_t'{1, 0, 0,           0, B+'h108,   1, B+'h104,   0}); // fill hold
    vec.push_back(vec_t'{1, 1, B+'h200,     0, B+'h108,   0, 0,         0}); // stall+redirect
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h200,   0, 0,         0}); // hold gone
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h204,   1, B+'h204,   0});
    vec.push_back(vec_t'{0, 1, B+'h102,     0, B+'h208,   0, 0,         1}); // misaligned
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h100,   0, 0,         0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+'h104,   1, B+'h104,   0});
    vec.push_back(vec_t'{0, 1, 32'hFFFF_FFFC, 0, B+'h108, 0, 0,         0}); // wrap
    vec.push_back(vec_t'{0, 0, 0,           1, 32'hFFFF_FFFC, 0, 0,     0});
    vec.push_back(vec_t'{0, 0, 0,           1, 32'h0,     1, 32'h0,     0});
    vec.push_back(vec_t'{0, 0, 0,           1, 32'h4,     1, 32'h4,     0});
    vec.push_back(vec_t'{1, 0, 0,           0, 32'h8,     1, 32'h4,     0}); // fill hold
    vec.push_back(vec_t'{0, 1, B,           0, 32'h8,     0, 0,         0}); // release+redirect
    vec.push_back(vec_t'{0, 0, 0,           1, B,         0, 0,         0});
    vec.push_back(vec_t'{0, 0, 0,           1, B+4,       1, B+4,       0});

    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {31'b0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, B);
    chk("rst.valid", {31'b0, id_valid}, 32'd0);
    chk("rst.instr", id_instr, 32'h0);
    chk("rst.pc4", id_pc_plus4, 32'h0);
    chk("rst.mis", {31'b0, misalign}, 32'd0);
    reset = 1'b0;

    foreach (vec[i]) begin
      stall = vec[i].stall;
      redirect_valid = vec[i].rv;
      redirect_target = vec[i].rt;
      #1;
      chk($sformatf("v%0d.req", i), {31'b0, imem_req}, {31'b0, vec[i].expReq});
      chk($sformatf("v%0d.addr", i), imem_addr, vec[i].expAddr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.mis", i), {31'b0, misalign}, {31'b0, vec[i].expMis});
      if (vec[i].expValid) begin
        chkId($sformatf("v%0d", i), vec[i].expPc4);
      end else begin
        chk($sformatf("v%0d.valid", i), {31'b0, id_valid}, 32'd0);
        chk($sformatf("v%0d.instr", i), id_instr, 32'h0);
      end
    end

    // Irregular stall pattern: every released edge must deliver the next PC exactly once.
    stall = 1'b0;
    redirect_valid = 1'b0;
    nextPc4 = B + 32'd8;
    pat = 32'b0110_0011_1000_0101_1110_0000_1101_0010;
    for (int i = 0; i < 32; i++) begin
      stall = pat[i];
      #1;
      if (pat[i]) chk($sformatf("s%0d.req", i), {31'b0, imem_req}, 32'd0);
      @(posedge clk);
      #1;
      if (pat[i]) begin
        chkId($sformatf("s%0d.frozen", i), nextPc4 - 32'd4);
      end else begin
        chkId($sformatf("s%0d.next", i), nextPc4);
        nextPc4 = nextPc4 + 32'd4;
      end
    end

    // Mid-stream reset, then restart latency from RESET_PC.
    stall = 1'b0;
    reset = 1'b1;
    #1;
    chk("rr.req", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("rr.valid", {31'b0, id_valid}, 32'd0);
    chk("rr.addr", imem_addr, B);
    reset = 1'b0;
    #1;
    chk("rr.req1", {31'b0, imem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk("rr.bubble", {31'b0, id_valid}, 32'd0);
    chk("rr.addr1", imem_addr, B + 32'd4);
    @(posedge clk);
    #1;
    chkId("rr.first", B + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
